// File: rtl/uart_wb_bridge32.sv
// 32-bit Wishbone slave to 8-bit Wishbone master bridge for the UART register file.
// Selected byte lanes are issued as separate UART cycles in ascending order; read bytes merge back.
module uart_wb_bridge32 #(
  parameter int unsigned UART_AW = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [UART_AW-1:0] s_adr_i,
  input  logic [31:0]        s_dat_i,
  output logic [31:0]        s_dat_o,
  input  logic [3:0]         s_sel_i,
  input  logic               s_we_i,
  input  logic               s_stb_i,
  input  logic               s_cyc_i,
  output logic               s_ack_o,
  output logic               s_err_o,
  output logic [UART_AW-1:0] m_adr_o,
  output logic [7:0]         m_dat_o,
  input  logic [7:0]         m_dat_i,
  output logic               m_we_o,
  output logic               m_stb_o,
  output logic               m_cyc_o,
  input  logic               m_ack_i
);

  localparam int unsigned WW = UART_AW - 2;

  typedef enum logic [1:0] {IDLE, BUS, GAP, DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    mask_q, mask_d;
  logic [1:0]    lane_q, lane_d;
  logic [WW-1:0] word_q, word_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [31:0]   rbuf_q, rbuf_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          in_bus;
  logic          in_done;
  logic          unused_adr;

  assign unused_adr = ^s_adr_i[1:0];

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    lane_d  = lane_q;
    word_d  = word_q;
    we_d    = we_q;
    err_d   = err_q;
    wdat_d  = wdat_q;
    rbuf_d  = rbuf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          word_d  = s_adr_i[UART_AW-1:2];
          we_d    = s_we_i;
          wdat_d  = s_dat_i;
          mask_d  = s_sel_i;
          rbuf_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          lane_d  = low_lane(s_sel_i);
          state_d = (s_sel_i == 4'd0) ? DONE : BUS;
        end
      end
      BUS: begin
        // Ack is tested before the timeout so a last-cycle ack completes normally.
        if (!s_cyc_i) begin
          mask_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (m_ack_i) begin
          if (!we_q) rbuf_d[{lane_q, 3'b000} +: 8] = m_dat_i;
          mask_d  = mask_q & ~(4'b0001 << lane_q);
          cnt_d   = '0;
          state_d = (mask_d == 4'd0) ? DONE : GAP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          mask_d  = '0;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (!s_cyc_i) begin
          mask_d  = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          lane_d  = low_lane(mask_q);
          state_d = BUS;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdat_q  <= '0;
      rbuf_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      we_q    <= we_d;
      err_q   <= err_d;
      wdat_q  <= wdat_d;
      rbuf_q  <= rbuf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_bus  = (state_q == BUS);
  assign in_done = (state_q == DONE);

  assign m_cyc_o = in_bus;
  assign m_stb_o = in_bus;
  assign m_we_o  = in_bus & we_q;
  assign m_adr_o = in_bus ? {word_q, lane_q} : '0;
  assign m_dat_o = in_bus ? wdat_q[{lane_q, 3'b000} +: 8] : '0;

  assign s_ack_o = in_done & ~err_q;
  assign s_err_o = in_done & err_q;
  assign s_dat_o = (in_done && !we_q) ? rbuf_q : '0;

endmodule

// File: tb/tb_uart_wb_bridge32.sv
// Randomised scoreboard bench for uart_wb_bridge32 with a behavioural UART register slave.
module tb_uart_wb_bridge32;

  localparam int TO = 16;

  typedef struct packed {
    logic [2:0] adr;
    logic       we;
    logic [7:0] dat;
  } uart_t;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  s_adr_i = '0;
  logic [31:0] s_dat_i = '0;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_i = '0;
  logic        s_we_i = 1'b0;
  logic        s_stb_i = 1'b0;
  logic        s_cyc_i = 1'b0;
  logic        s_ack_o;
  logic        s_err_o;
  logic [2:0]  m_adr_o;
  logic [7:0]  m_dat_o;
  logic [7:0]  m_dat_i;
  logic        m_we_o;
  logic        m_stb_o;
  logic        m_cyc_o;
  logic        m_ack_i;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] model_mem [8];
  logic [7:0] slv_mem [8];
  uart_t      uart_q [$];
  rsp_t       rsp_q [$];

  int lat = 0;
  bit noack = 1'b0;
  int wait_cnt = 0;
  int stb_run = 0;
  int low_run = 0;
  int last_run = 0;
  int bursts = 0;
  int txn_bursts = 0;
  bit prev_stb = 1'b0;
  bit dat_chk = 1'b0;

  uart_wb_bridge32 #(.UART_AW(3), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .s_adr_i  (s_adr_i),
    .s_dat_i  (s_dat_i),
    .s_dat_o  (s_dat_o),
    .s_sel_i  (s_sel_i),
    .s_we_i   (s_we_i),
    .s_stb_i  (s_stb_i),
    .s_cyc_i  (s_cyc_i),
    .s_ack_o  (s_ack_o),
    .s_err_o  (s_err_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_dat_i  (m_dat_i),
    .m_we_o   (m_we_o),
    .m_stb_o  (m_stb_o),
    .m_cyc_o  (m_cyc_o),
    .m_ack_i  (m_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // UART register slave: acks after 'lat' extra strobe cycles, checks each accepted cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ack_i  = 1'b0;
      m_dat_i  = '0;
      wait_cnt = 0;
    end else if (m_ack_i) begin
      m_ack_i  = 1'b0;
      m_dat_i  = 8'($urandom);
      wait_cnt = 0;
    end else if (m_stb_o && m_cyc_o) begin
      if (!noack && wait_cnt == lat) begin
        uart_t u;
        m_ack_i  = 1'b1;
        wait_cnt = 0;
        if (m_we_o) slv_mem[m_adr_o] = m_dat_o;
        else        m_dat_i = slv_mem[m_adr_o];
        if (uart_q.size() == 0) begin
          check("uart_unexpected_cycle", 32'(m_adr_o), 32'hFFFF_FFFF);
        end else begin
          u = uart_q.pop_front();
          check("uart_adr", 32'(m_adr_o), 32'(u.adr));
          check("uart_we", 32'(m_we_o), 32'(u.we));
          if (u.we) check("uart_wdat", 32'(m_dat_o), 32'(u.dat));
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Response monitor and strobe-shape tracker.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ack_err_exclusive", 32'(s_ack_o & s_err_o), 32'd0);
      if (s_ack_o || s_err_o) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'({s_ack_o, s_err_o}), 32'd0);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("rsp_kind", 32'({s_ack_o, s_err_o}), r.err ? 32'd1 : 32'd2);
          if (!r.err) check("rsp_rdata", s_dat_o, r.dat);
        end
        dat_chk = 1'b1;
      end else if (dat_chk) begin
        check("rdata_cleared", s_dat_o, 32'd0);
        dat_chk = 1'b0;
      end
      if (m_stb_o) begin
        if (!prev_stb) begin
          bursts++;
          if (txn_bursts > 0) check("gap_len", 32'(low_run), 32'd1);
          txn_bursts++;
        end
        stb_run++;
        low_run = 0;
      end else begin
        if (prev_stb) last_run = stb_run;
        stb_run = 0;
        low_run++;
      end
      if (!s_cyc_i) txn_bursts = 0;
      prev_stb = m_stb_o;
    end
  end

  task automatic run_txn(input logic [2:0] adr, input logic [3:0] sel, input logic we,
                         input logic [31:0] dat, input int l, input bit na);
    int n = 0;
    int waited = 0;
    int exp_cyc;
    int b0;
    logic [31:0] rd = '0;
    uart_t u;
    rsp_t r;
    repeat (2) @(negedge clk);
    lat = l;
    noack = na;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        n++;
        if (!na) begin
          u.adr = {adr[2], 2'(i)};
          u.we  = we;
          u.dat = dat[8*i +: 8];
          uart_q.push_back(u);
          if (we) model_mem[u.adr] = dat[8*i +: 8];
          else    rd[8*i +: 8] = model_mem[u.adr];
        end
      end
    end
    r.err = na && (n > 0);
    r.dat = we ? 32'd0 : rd;
    rsp_q.push_back(r);
    exp_cyc = (n == 0) ? 1 : (r.err ? TO + 1 : n * (l + 2));
    b0 = bursts;
    s_adr_i = adr; s_sel_i = sel; s_we_i = we; s_dat_i = dat;
    s_cyc_i = 1'b1; s_stb_i = 1'b1;
    while (waited < 200) begin
      @(negedge clk);
      waited++;
      if (s_ack_o || s_err_o) break;
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    check("latency", 32'(waited), 32'(exp_cyc));
    check("lanes_issued", 32'(bursts - b0), r.err ? 32'd1 : 32'(n));
  endtask

  task automatic run_abort();
    uart_t u;
    int waited = 0;
    repeat (2) @(negedge clk);
    lat = 3;
    noack = 1'b0;
    u.adr = 3'd0; u.we = 1'b1; u.dat = 8'h5A;
    uart_q.push_back(u);
    model_mem[0] = 8'h5A;
    s_adr_i = 3'd0; s_sel_i = 4'hF; s_we_i = 1'b1; s_dat_i = 32'h1234_565A;
    s_cyc_i = 1'b1; s_stb_i = 1'b1;
    while (waited < 100) begin
      @(negedge clk);
      waited++;
      if (m_stb_o && m_adr_o[1:0] == 2'd1) break;
    end
    check("abort_reached_lane1", 32'(m_adr_o[1:0]), 32'd1);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge clk);
    check("abort_stb_drop", 32'(m_stb_o), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", 32'({s_ack_o, s_err_o, m_stb_o}), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 8'($urandom);
      slv_mem[i]   = model_mem[i];
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_adr_i = 3'($urandom); s_dat_i = $urandom; s_sel_i = 4'($urandom);
      s_we_i = 1'($urandom); s_stb_i = 1'($urandom); s_cyc_i = 1'($urandom);
      #1;
      check("reset_outputs",
            32'({s_dat_o != 32'd0, s_ack_o, s_err_o, m_adr_o, m_dat_o, m_we_o, m_stb_o, m_cyc_o}),
            32'd0);
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", 32'({m_stb_o, m_cyc_o, s_ack_o, s_err_o}), 32'd0);
    end

    run_txn(3'd4, 4'b0101, 1'b1, 32'hAABB_CCDD, 0, 1'b0);
    model_mem[0] = 8'h11; model_mem[1] = 8'h22; model_mem[2] = 8'h33; model_mem[3] = 8'h44;
    for (int i = 0; i < 4; i++) slv_mem[i] = model_mem[i];
    run_txn(3'd0, 4'b1111, 1'b0, 32'd0, 0, 1'b0);
    run_txn(3'd4, 4'b0000, 1'b0, 32'd0, 0, 1'b0);
    run_txn(3'd4, 4'b0000, 1'b1, 32'hFFFF_FFFF, 2, 1'b0);
    run_txn(3'd4, 4'b1111, 1'b0, 32'd0, 0, 1'b1);
    @(negedge clk);
    check("timeout_stb_len", 32'(last_run), 32'(TO));
    run_txn(3'd1, 4'b0100, 1'b0, 32'd0, TO - 1, 1'b0);
    run_abort();
    run_txn(3'd0, 4'b1111, 1'b0, 32'd0, 1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_txn(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              $urandom, $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clk);
    check("uart_queue_drained", 32'(uart_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
